// File: rtl/inst_encoder_pkg.sv
// Shared CPU encodings: instruction-format codes (same as the decoder) and encoder FSM states.
package inst_encoder_pkg;

  typedef enum logic [2:0] {
    IMM_R = 3'b000,
    IMM_I = 3'b001,
    IMM_S = 3'b010,
    IMM_B = 3'b011,
    IMM_U = 3'b100,
    IMM_J = 3'b101
  } imm_type_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } enc_state_e;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  // True when every bit from msb upward equals bit msb (value fits a signed msb+1 field).
  function automatic logic sext_ok(input logic [31:0] v, input int msb);
    logic [31:0] mask;
    mask = 32'hFFFF_FFFF << msb;
    return ((v & mask) == mask) || ((v & mask) == 32'h0);
  endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational field placement for R/I/S/B/U/J words plus immediate range check.
// Zero latency; illegal formats give inst 0 with err set.
module imm_pack
  import inst_encoder_pkg::*;
(
  input  logic [2:0]  imm_type,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic [31:0] imm,
  output logic [31:0] inst,
  output logic        err
);

  always_comb begin
    inst = '0;
    err  = 1'b0;
    case (imm_type)
      IMM_R: inst = {funct7, rs2, rs1, funct3, rd, opcode};
      IMM_I: begin
        inst = {imm[11:0], rs1, funct3, rd, opcode};
        err  = !sext_ok(imm, 11);
      end
      IMM_S: begin
        inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        err  = !sext_ok(imm, 11);
      end
      IMM_B: begin
        inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        err  = imm[0] || !sext_ok(imm, 12);
      end
      IMM_U: begin
        inst = {imm[31:12], rd, opcode};
        err  = |imm[11:0];
      end
      IMM_J: begin
        inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        err  = imm[0] || !sext_ok(imm, 20);
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Instruction encoder: packs fields into 32-bit words tagged with sequential byte addresses.
// One-cycle latency into an output register; in_ready drops while a word waits on out_ready.
module inst_encoder
  import inst_encoder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic [31:0] base_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  imm_type,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_addr,
  output logic        out_err,
  output logic [15:0] inst_count,
  output logic [15:0] err_count
);

  enc_state_e  state, state_nxt;
  logic [31:0] wr_ptr;
  logic [31:0] enc_inst;
  logic        enc_err;
  logic        accept;
  logic        out_fire;

  imm_pack u_imm_pack (
    .imm_type (imm_type),
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7   (funct7),
    .rs1      (rs1),
    .rs2      (rs2),
    .rd       (rd),
    .imm      (imm),
    .inst     (enc_inst),
    .err      (enc_err)
  );

  assign in_ready = (state == ST_RUN) && !stop && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // DRAIN also exits when nothing is left pending, so a stop coinciding with the
  // last handshake cannot strand the FSM.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_RUN;
      ST_RUN:   if (stop) state_nxt = out_valid ? ST_DRAIN : ST_IDLE;
      ST_DRAIN: if (!out_valid || out_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      out_valid  <= 1'b0;
      out_inst   <= '0;
      out_addr   <= '0;
      out_err    <= 1'b0;
      inst_count <= '0;
      err_count  <= '0;
    end else begin
      if (state == ST_IDLE && start) begin
        wr_ptr     <= base_addr;
        inst_count <= '0;
        err_count  <= '0;
      end else if (out_fire) begin
        if (inst_count != CNT_MAX)           inst_count <= inst_count + 16'd1;
        if (out_err && err_count != CNT_MAX) err_count  <= err_count + 16'd1;
      end

      if (accept) begin
        out_valid <= 1'b1;
        out_inst  <= enc_inst;
        out_addr  <= wr_ptr;
        out_err   <= enc_err;
        wr_ptr    <= wr_ptr + 32'd4;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: directed cases with literal expectations, then random traffic
// checked every cycle against a behavioural model.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst, start, stop, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [31:0] base_addr, imm, out_inst, out_addr;
  logic [2:0]  imm_type, funct3;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rs1, rs2, rd;
  logic [15:0] inst_count, err_count;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // model state: 0 idle, 1 run, 2 drain
  int          m_state = 0;
  logic [31:0] m_ptr = '0, m_inst = '0, m_addr = '0;
  logic        m_vld = 1'b0, m_err = 1'b0;
  int          m_ic = 0, m_ec = 0;

  always #5 clk = ~clk;

  inst_encoder dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .imm_type(imm_type), .opcode(opcode),
    .funct3(funct3), .funct7(funct7), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_addr(out_addr), .out_err(out_err), .inst_count(inst_count), .err_count(err_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Encoding from the instruction-format rules, using signed ranges and shifts.
  function automatic logic [32:0] ref_encode(input logic [2:0] t, input logic [6:0] op,
      input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] r1, input logic [4:0] r2,
      input logic [4:0] d, input logic [31:0] im);
    int          si;
    logic [31:0] w, base_rd, r1p, r2p, f3p;
    logic        e;
    si      = int'($signed(im));
    base_rd = (32'(d) << 7) | 32'(op);
    r1p     = 32'(r1) << 15;
    r2p     = 32'(r2) << 20;
    f3p     = 32'(f3) << 12;
    e       = 1'b0;
    case (t)
      3'd0: w = (32'(f7) << 25) | r2p | r1p | f3p | base_rd;
      3'd1: begin
        e = si < -2048 || si > 2047;
        w = ((im & 32'hFFF) << 20) | r1p | f3p | base_rd;
      end
      3'd2: begin
        e = si < -2048 || si > 2047;
        w = (((im >> 5) & 32'h7F) << 25) | r2p | r1p | f3p | ((im & 32'h1F) << 7) | 32'(op);
      end
      3'd3: begin
        e = (im & 32'h1) != 0 || si < -4096 || si > 4095;
        w = (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | r2p | r1p | f3p |
            (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7) | 32'(op);
      end
      3'd4: begin
        e = (im & 32'hFFF) != 0;
        w = (im & 32'hFFFFF000) | base_rd;
      end
      3'd5: begin
        e = (im & 32'h1) != 0 || si < -1048576 || si > 1048575;
        w = (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21) |
            (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12) | base_rd;
      end
      default: begin
        e = 1'b1;
        w = 32'h0;
      end
    endcase
    return {e, w};
  endfunction

  always @(posedge clk) begin
    logic        rdy, acc, hs;
    logic [32:0] enc;
    if (rst) begin
      m_state = 0; m_ptr = '0; m_vld = 1'b0; m_inst = '0; m_addr = '0; m_err = 1'b0;
      m_ic = 0; m_ec = 0;
    end else begin
      rdy = (m_state == 1) && !stop && (!m_vld || out_ready);
      acc = in_valid && rdy;
      hs  = m_vld && out_ready;
      enc = ref_encode(imm_type, opcode, funct3, funct7, rs1, rs2, rd, imm);
      if (hs) begin
        if (m_ic < 65535) m_ic++;
        if (m_err && m_ec < 65535) m_ec++;
      end
      case (m_state)
        0: if (start) begin m_state = 1; m_ptr = base_addr; m_ic = 0; m_ec = 0; end
        1: if (stop) m_state = m_vld ? 2 : 0;
        default: if (!m_vld || out_ready) m_state = 0;
      endcase
      if (acc) begin
        m_vld = 1'b1; m_inst = enc[31:0]; m_err = enc[32]; m_addr = m_ptr;
        m_ptr = m_ptr + 32'd4;
      end else if (hs) begin
        m_vld = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 32'(in_ready),
          32'((m_state == 1) && !stop && (!m_vld || out_ready)));
      chk("out_valid", 32'(out_valid), 32'(m_vld));
      chk("out_inst", out_inst, m_inst);
      chk("out_addr", out_addr, m_addr);
      chk("out_err", 32'(out_err), 32'(m_err));
      chk("inst_count", 32'(inst_count), m_ic);
      chk("err_count", 32'(err_count), m_ec);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input logic [2:0] t, input logic [6:0] op, input logic [2:0] f3,
      input logic [6:0] f7, input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
      input logic [31:0] im);
    imm_type = t; opcode = op; funct3 = f3; funct7 = f7; rs1 = a; rs2 = b; rd = d; imm = im;
  endtask

  task automatic send(input logic [2:0] t, input logic [6:0] op, input logic [2:0] f3,
      input logic [6:0] f7, input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
      input logic [31:0] im);
    set_word(t, op, f3, f7, a, b, d, im);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [32:0] r;
    rst = 1'b1; start = 1'b0; stop = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    base_addr = '0;
    set_word(3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);

    r = ref_encode(3'd1, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd5);
    chk("ref_addi", r[31:0], 32'h00500093);
    r = ref_encode(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC);
    chk("ref_beq", r[31:0], 32'hFE000EE3);
    r = ref_encode(3'd5, 7'h6F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd2048);
    chk("ref_jal", r[31:0], 32'h001000EF);

    repeat (2) tick();
    chk_en = 1'b1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_inst_count", 32'(inst_count), 32'd0);

    rst = 1'b0; start = 1'b1; base_addr = 32'h1000;
    tick();
    start = 1'b0; out_ready = 1'b1;

    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd5);
    chk("addi_inst", out_inst, 32'h00500093);
    chk("addi_addr", out_addr, 32'h1000);
    chk("addi_err", 32'(out_err), 32'd0);
    send(3'd2, 7'h23, 3'd2, 7'd0, 5'd1, 5'd2, 5'd0, 32'd8);
    chk("sw_inst", out_inst, 32'h0020A423);
    chk("sw_addr", out_addr, 32'h1004);
    send(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC);
    chk("beq_inst", out_inst, 32'hFE000EE3);
    chk("beq_addr", out_addr, 32'h1008);
    send(3'd5, 7'h6F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd2048);
    chk("jal_inst", out_inst, 32'h001000EF);
    send(3'd4, 7'h37, 3'd0, 7'd0, 5'd0, 5'd0, 5'd5, 32'h12345000);
    chk("lui_inst", out_inst, 32'h123452B7);
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd2048);
    chk("i_range_err", 32'(out_err), 32'd1);
    send(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd3);
    chk("b_odd_err", 32'(out_err), 32'd1);
    send(3'd7, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd0);
    chk("illegal_err", 32'(out_err), 32'd1);
    chk("illegal_inst", out_inst, 32'h0);
    chk("illegal_addr", out_addr, 32'h101C);
    tick();
    chk("err_count", 32'(err_count), 32'd3);
    chk("inst_count", 32'(inst_count), 32'd8);

    // backpressure: first word held while the next one waits
    out_ready = 1'b0;
    send(3'd0, 7'h33, 3'd0, 7'd0, 5'd2, 5'd3, 5'd1, 32'd0);
    set_word(3'd1, 7'h13, 3'd0, 7'd0, 5'd2, 5'd0, 5'd2, 32'hFFFFFFFF);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_inst", out_inst, 32'h003100B3);
      chk("hold_addr", out_addr, 32'h1020);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1 chk("release_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("next_inst", out_inst, 32'hFFF10113);
    chk("next_addr", out_addr, 32'h1024);
    tick();

    // stop with a word pending
    out_ready = 1'b0;
    send(3'd0, 7'h33, 3'd0, 7'd0, 5'd4, 5'd5, 5'd6, 32'd0);
    stop = 1'b1;
    tick();
    stop = 1'b0; in_valid = 1'b1;
    #1 chk("drain_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("drain_pending", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("drain_done", 32'(out_valid), 32'd0);
    #1 chk("idle_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;

    // pointer wrap
    start = 1'b1; base_addr = 32'hFFFFFFFC;
    tick();
    start = 1'b0;
    send(3'd0, 7'h33, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'd0);
    chk("wrap_addr0", out_addr, 32'hFFFFFFFC);
    send(3'd0, 7'h33, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'd0);
    chk("wrap_addr1", out_addr, 32'h0);
    tick();

    // reset during DRAIN
    out_ready = 1'b0;
    send(3'd4, 7'h37, 3'd0, 7'd0, 5'd0, 5'd0, 5'd3, 32'hABCDE000);
    stop = 1'b1;
    tick();
    stop = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_drain_valid", 32'(out_valid), 32'd0);
    chk("rst_drain_inst", out_inst, 32'h0);
    chk("rst_drain_addr", out_addr, 32'h0);
    chk("rst_drain_err", 32'(out_err), 32'd0);
    chk("rst_drain_cnt", 32'(inst_count), 32'd0);

    // random traffic against the model
    for (int n = 0; n < 4000; n++) begin
      logic [31:0] v;
      rst       = ($urandom_range(0, 499) == 0);
      start     = ($urandom_range(0, 7) == 0);
      stop      = ($urandom_range(0, 39) == 0);
      base_addr = (n % 3 == 0) ? 32'hFFFFFFF0 + 32'($urandom_range(0, 3) * 4) : $urandom;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 3))
        0:       v = $urandom;
        1:       v = 32'($urandom_range(0, 8191)) - 32'd4096;
        2:       v = 32'($urandom_range(0, 2097151)) - 32'd1048576;
        default: v = $urandom & 32'hFFFFF000;
      endcase
      set_word(3'($urandom_range(0, 7)), 7'($urandom), 3'($urandom), 7'($urandom),
               5'($urandom), 5'($urandom), 5'($urandom), v);
      tick();
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1: in IDLE, load write pointer from base_addr, clear counters, enter RUN.
REQ-004 SHALL have port stop, input, 1: end the current encode session.
REQ-005 SHALL have port base_addr, input, 32: first instruction-memory byte address.
REQ-006 SHALL have ports in_valid (input, 1) and in_ready (output, 1): field-side handshake.
REQ-007 SHALL have port imm_type, input, 3: 000 R, 001 I, 010 S, 011 B, 100 U, 101 J, 110/111 illegal.
REQ-008 SHALL have ports opcode (input, 7), funct3 (input, 3), funct7 (input, 7), rs1/rs2/rd (input, 5 each) and imm (input, 32, full byte-offset value).
REQ-009 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_inst (output, 32), out_addr (output, 32) and out_err (output, 1).
REQ-010 SHALL have ports inst_count and err_count, each output, 16: instructions emitted and errored.

Function
REQ-011 SHALL implement FSM IDLE/RUN/DRAIN: IDLE->RUN on start; RUN->IDLE on stop if !out_valid, else RUN->DRAIN; DRAIN->IDLE on output handshake.
REQ-012 SHALL hold start ignored outside IDLE and stop ignored in IDLE and DRAIN.
REQ-013 SHALL assert in_ready = (state==RUN) && !stop && (!out_valid || out_ready).
REQ-014 SHALL register an encoded word on an input handshake, one-cycle latency; out_* SHALL stay stable while out_valid && !out_ready.
REQ-015 SHALL tag each accepted word with the write pointer as out_addr, then advance the pointer by 4, wrapping modulo 2^32.
REQ-016 SHALL place R as funct7|rs2|rs1|funct3|rd|opcode.
REQ-017 SHALL place I as imm[11:0]|rs1|funct3|rd|opcode.
REQ-018 SHALL place S as imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode.
REQ-019 SHALL place B as imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode.
REQ-020 SHALL place U as imm[31:12]|rd|opcode.
REQ-021 SHALL place J as imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
REQ-022 SHALL set out_err when: I/S imm not sign-extended from bit 11; B imm[0]!=0 or not sign-extended from bit 12; J imm[0]!=0 or not sign-extended from bit 20; U imm[11:0]!=0; type 110/111. R SHALL never error.
REQ-023 SHALL, on error, still emit the truncated-field encoding (illegal types: out_inst=0) and consume an address.
REQ-024 SHALL increment inst_count on each output handshake, and err_count as well when out_err; both saturate at 0xFFFF.
REQ-025 SHALL complete a pending output in DRAIN regardless of stop; in_valid without in_ready SHALL be ignored.

Reset
REQ-026 SHALL, on rst, set state IDLE, out_valid 0, out_inst 0, out_addr 0, out_err 0, write pointer 0, counters 0; rst mid-session drops any pending word.
REQ-027 SHALL give rst priority over start, stop and all handshakes in the same cycle.

Structure
REQ-028 SHALL take imm_type codes and FSM state encodings from the shared CPU package, identical to the decoder's imm_type encoding.
REQ-029 SHALL isolate field placement plus range check in one combinational sub-module, imm_pack.

Verification
REQ-030 SHALL cover: start, base_addr=0x1000; I addi opcode 0x13, rd=1, rs1=0, imm=5 -> out_inst 0x00500093, addr 0x1000, err 0.
REQ-031 SHALL cover: S opcode 0x23, f3=2, rs1=1, rs2=2, imm=8 -> 0x0020A423; B opcode 0x63, f3=0, imm=-4 -> 0xFE000EE3; addr 0x1004, 0x1008.
REQ-032 SHALL cover: J opcode 0x6F, rd=1, imm=2048 -> 0x001000EF; U opcode 0x37, rd=5, imm=0x12345000 -> 0x123452B7.
REQ-033 SHALL cover: I imm=2048, B imm=3, imm_type=111 -> out_err 1 each, err_count 3, addresses still advance.
REQ-034 SHALL cover: out_ready=0 for 5 cycles with in_valid high -> one word held stable, in_ready 0; release -> next word next cycle.
REQ-035 SHALL cover: stop with word pending -> DRAIN until handshake, then IDLE; base_addr=0xFFFFFFFC, two words -> addr 0xFFFFFFFC, 0x00000000; rst mid-DRAIN -> all outputs 0.
